alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; also the mul/div iteration count.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 op  input  2  opcode, latched at accepted start: 00 add, 01 sub, 10 mul (Booth radix-2), 11 div (restoring).
REQ-006 q0, q_m1  input  1 each  datapath Q[0] and Booth extra bit.
REQ-007 a_sign  input  1  datapath A sign bit after division subtract.
REQ-008 m_zero  input  1  datapath M register equals zero.
REQ-009 c0..c7  output  1 each  c0 load M from inbus; c1 load Q from inbus; c2 A = A +/- M; c3 subtract select; c4 arithmetic shift right A:Q:q_m1; c5 shift left A:Q; c6 set Q[0]=1; c7 drive outbus.
REQ-010 out_sel  output  1  outbus source: 0 = A, 1 = Q.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on the final output cycle.
REQ-013 err  output  1  one-cycle pulse: divide by zero.

Function
REQ-014 Registered state, latched op, log2(WIDTH)-bit iteration counter; c0..c7, out_sel, done and err SHALL be combinational decodes of state plus status inputs.
REQ-015 States: IDLE, LOAD_M, LOAD_Q, EXEC, B_TEST, B_SHIFT, D_SHIFT, D_SUB, D_CHECK, OUT_A, OUT_Q.
REQ-016 IDLE: start=1 -> LOAD_M and latch op; else stay; all outputs 0.
REQ-017 LOAD_M: c0=1 -> LOAD_Q.  LOAD_Q: c1=1, counter cleared -> EXEC (add/sub), B_TEST (mul), D_SHIFT (div).
REQ-018 EXEC: c2=1, c3=op[0] -> OUT_A.
REQ-019 B_TEST: {q0,q_m1}=10 -> c2=1,c3=1; 01 -> c2=1,c3=0; 00/11 -> c2=0; always -> B_SHIFT.
REQ-020 B_SHIFT: c4=1, counter+1; counter==WIDTH-1 -> OUT_A else B_TEST.
REQ-021 D_SHIFT: if m_zero=1 -> err=1, no controls, -> IDLE; else c5=1 -> D_SUB.
REQ-022 D_SUB: c2=1, c3=1 -> D_CHECK.
REQ-023 D_CHECK: a_sign=1 -> c2=1,c3=0 (restore); a_sign=0 -> c6=1; counter+1; counter==WIDTH-1 -> OUT_A else D_SHIFT.
REQ-024 OUT_A: c7=1, out_sel=0; add/sub -> done=1, -> IDLE; mul/div -> OUT_Q.
REQ-025 OUT_Q: c7=1, out_sel=1, done=1 -> IDLE.
REQ-026 Latency (start high at edge k, WIDTH=8): add/sub done at cycle k+4; mul OUT_A k+19, done k+20; div OUT_A k+27, done k+28.
REQ-027 start while busy SHALL be ignored; op changes while busy SHALL have no effect.
REQ-028 start high on the cycle done pulses SHALL NOT be accepted; it is accepted from IDLE on the next edge if still high.
REQ-029 Counter wrap from WIDTH-1 to 0 SHALL coincide with leaving the iteration loop.
REQ-030 At most one of c0, c1, c2, c4, c5, c6, c7 SHALL be high in any cycle; c2 and c6 are exclusive.

Reset
REQ-031 rst=1 at any edge, including mid-operation, SHALL force IDLE, counter 0, latched op 00 on that edge; all outputs 0 the following cycle.
REQ-032 rst SHALL dominate start on the same edge.

Structure
REQ-033 Shared package alu_pkg: state enum, opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV), default WIDTH.
REQ-034 One sub-module alu_iter_counter: clear, increment, terminal-count flag at WIDTH-1, synchronous reset.

Verification
REQ-035 op=00, start pulse -> c0, c1, c2 (c3=0), c7 (out_sel=0, done) on consecutive cycles k+1..k+4; busy low k+5.
REQ-036 op=10, status model of 8-bit Booth with M=3, Q=-5 -> exactly 8 B_TEST/B_SHIFT pairs; c2/c3 match q0/q_m1 each test; bench datapath yields A:Q = -15; done k+20.
REQ-037 op=11, M=3, Q=20 -> 8 D_SHIFT/D_SUB/D_CHECK triples; outbus remainder 2 (out_sel 0) then quotient 6 (out_sel 1, done) at k+27/k+28.
REQ-038 op=11, m_zero=1 -> err pulse at k+3, no c2/c5/c7, busy low k+4, no done.
REQ-039 rst at k+10 of a mul -> all outputs 0 at k+11; new start then completes a clean add.
REQ-040 start held high continuously -> back-to-back operations with exactly one IDLE cycle between done and next c0; start pulses while busy ignored.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU control sequencer: state encoding,
// opcodes and default operand width.
package alu_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    EXEC,
    B_TEST,
    B_SHIFT,
    D_SHIFT,
    D_SUB,
    D_CHECK,
    OUT_A,
    OUT_Q
  } state_t;

endpackage

// File: rtl/alu_iter_counter.sv
// Iteration counter for the mul/div loops.
// Ports: clk, rst (sync, high), clr, inc in; tc high at count WIDTH-1.
module alu_iter_counter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == CW'(WIDTH - 1));

  // Wrap explicitly so non power-of-two widths also return to 0
  // on the same increment that leaves the loop.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer for an add/sub/Booth-mul/restoring-div datapath.
// Ports: start/op request, datapath status in; c0..c7, out_sel,
// busy, done, err out (controls decoded from state and status).
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       q0,
  input  logic       q_m1,
  input  logic       a_sign,
  input  logic       m_zero,
  output logic       c0,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       c4,
  output logic       c5,
  output logic       c6,
  output logic       c7,
  output logic       out_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] op_q;
  logic [1:0] op_d;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_tc;

  alu_iter_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(cnt_inc),
    .tc (cnt_tc)
  );

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    c0      = 1'b0;
    c1      = 1'b0;
    c2      = 1'b0;
    c3      = 1'b0;
    c4      = 1'b0;
    c5      = 1'b0;
    c6      = 1'b0;
    c7      = 1'b0;
    out_sel = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_M;
          op_d    = op;
        end
      end
      LOAD_M: begin
        c0      = 1'b1;
        state_d = LOAD_Q;
      end
      LOAD_Q: begin
        c1      = 1'b1;
        cnt_clr = 1'b1;
        unique case (op_q)
          OP_MUL:  state_d = B_TEST;
          OP_DIV:  state_d = D_SHIFT;
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin
        c2      = 1'b1;
        c3      = op_q[0];
        state_d = OUT_A;
      end
      B_TEST: begin
        unique case ({q0, q_m1})
          2'b10: begin
            c2 = 1'b1;
            c3 = 1'b1;
          end
          2'b01:   c2 = 1'b1;
          default: c2 = 1'b0;
        endcase
        state_d = B_SHIFT;
      end
      B_SHIFT: begin
        c4      = 1'b1;
        cnt_inc = 1'b1;
        state_d = cnt_tc ? OUT_A : B_TEST;
      end
      D_SHIFT: begin
        if (m_zero) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          c5      = 1'b1;
          state_d = D_SUB;
        end
      end
      D_SUB: begin
        c2      = 1'b1;
        c3      = 1'b1;
        state_d = D_CHECK;
      end
      D_CHECK: begin
        // Negative trial remainder: add M back; else quotient bit is 1.
        if (a_sign) begin
          c2 = 1'b1;
        end else begin
          c6 = 1'b1;
        end
        cnt_inc = 1'b1;
        state_d = cnt_tc ? OUT_A : D_SHIFT;
      end
      OUT_A: begin
        c7 = 1'b1;
        if (op_q[1]) begin
          state_d = OUT_Q;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      OUT_Q: begin
        c7      = 1'b1;
        out_sel = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural 8-bit datapath closes the
// status loop; results compared against plain arithmetic.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic       q0;
  logic       q_m1;
  logic       a_sign;
  logic       m_zero;
  logic       c0, c1, c2, c3, c4, c5, c6, c7;
  logic       out_sel;
  logic       busy;
  logic       done;
  logic       err;

  alu_sequencer #(
    .WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .q0     (q0),
    .q_m1   (q_m1),
    .a_sign (a_sign),
    .m_zero (m_zero),
    .c0     (c0),
    .c1     (c1),
    .c2     (c2),
    .c3     (c3),
    .c4     (c4),
    .c5     (c5),
    .c6     (c6),
    .c7     (c7),
    .out_sel(out_sel),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural datapath driven by the control lines.
  logic [7:0] in_m;
  logic [7:0] in_q;
  logic [1:0] dp_op;
  logic [7:0] dp_a;
  logic [7:0] dp_q;
  logic [7:0] dp_m;
  logic       dp_qm1;
  logic [7:0] outbus;
  logic [11:0] ctrl;

  assign q0     = dp_q[0];
  assign q_m1   = dp_qm1;
  assign a_sign = dp_a[7];
  assign m_zero = (dp_m == 8'h00);
  assign outbus = c7 ? (out_sel ? dp_q : dp_a) : 8'h00;
  assign ctrl   = {c0, c1, c2, c3, c4, c5, c6, c7,
                   out_sel, done, err, busy};

  always @(posedge clk) begin
    if (c0) dp_m <= in_m;
    if (c1) begin
      dp_q   <= in_q;
      dp_a   <= dp_op[1] ? 8'h00 : in_q;
      dp_qm1 <= 1'b0;
    end
    if (c2) dp_a <= c3 ? dp_a - dp_m : dp_a + dp_m;
    if (c4) begin
      dp_a   <= {dp_a[7], dp_a[7:1]};
      dp_q   <= {dp_a[0], dp_q[7:1]};
      dp_qm1 <= dp_q[0];
    end
    if (c5) begin
      dp_a <= {dp_a[6:0], dp_q[7]};
      dp_q <= {dp_q[6:0], 1'b0};
    end
    if (c6) dp_q[0] <= 1'b1;
  end

  // Reference: {first outbus word, second outbus word}.
  function automatic logic [15:0] ref_model(input logic [1:0] o,
                                            input logic [7:0] m,
                                            input logic [7:0] q);
    logic signed [7:0] sm;
    logic signed [7:0] sq;
    int p;
    logic [7:0] r;
    sm = m;
    sq = q;
    case (o)
      OP_ADD: begin
        r = q + m;
        return {r, 8'h00};
      end
      OP_SUB: begin
        r = q - m;
        return {r, 8'h00};
      end
      OP_MUL: begin
        p = int'(sm) * int'(sq);
        return p[15:0];
      end
      default: return {q % m, q / m};
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
    case (o)
      OP_MUL:  return 20;
      OP_DIV:  return 28;
      default: return 4;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [7:0] mv, input logic [7:0] qv,
                        input logic [15:0] exp, input bit exp_err);
    int done_j = 0;
    int err_j  = 0;
    int idle_j = 0;
    int nout   = 0;
    int c2n    = 0;
    int c4n    = 0;
    int c5n    = 0;
    int bad    = 0;
    int lat;
    logic [7:0] o0 = 8'h00;
    logic [7:0] o1 = 8'h00;
    logic s0 = 1'b0;
    logic s1 = 1'b0;
    @(negedge clk);
    dp_op = o;
    in_m  = mv;
    in_q  = qv;
    op    = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    for (int j = 1; j <= 40 && idle_j == 0; j++) begin
      @(negedge clk);
      if (done && done_j == 0) done_j = j;
      if (err && err_j == 0) err_j = j;
      if (c7) begin
        if (nout == 0) begin
          o0 = outbus;
          s0 = out_sel;
        end else begin
          o1 = outbus;
          s1 = out_sel;
        end
        nout++;
      end
      if (c2) c2n++;
      if (c4) c4n++;
      if (c5) c5n++;
      if ($countones({c0, c1, c2, c4, c5, c6, c7}) > 1 || (c2 && c6))
        bad++;
      if (!busy) idle_j = j;
    end
    chk({tag, " onehot"}, bad, 0);
    if (exp_err) begin
      chk({tag, " err_cycle"}, err_j, 3);
      chk({tag, " no_done"}, done_j, 0);
      chk({tag, " idle_cycle"}, idle_j, 4);
      chk({tag, " no_out"}, nout, 0);
      chk({tag, " no_c2c5"}, c2n + c5n, 0);
    end else begin
      lat = exp_lat(o);
      chk({tag, " done_cycle"}, done_j, lat);
      chk({tag, " idle_cycle"}, idle_j, lat + 1);
      chk({tag, " no_err"}, err_j, 0);
      chk({tag, " nout"}, nout, o[1] ? 2 : 1);
      chk({tag, " out0"}, int'(o0), int'(exp[15:8]));
      chk({tag, " sel0"}, int'(s0), 0);
      if (o[1]) begin
        chk({tag, " out1"}, int'(o1), int'(exp[7:0]));
        chk({tag, " sel1"}, int'(s1), 1);
      end
      if (o == OP_MUL) chk({tag, " shifts"}, c4n, 8);
      if (o == OP_DIV) chk({tag, " dshifts"}, c5n, 8);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
    bit          err;
  } vec_t;

  vec_t vt[13];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int done1;
    int done2;
    int c0_after;
    int idle_j;
    logic [1:0] ro;
    logic [7:0] rm;
    logic [7:0] rq;

    vt[0]  = '{OP_ADD, 8'h07, 8'h05, 16'h0C00, 1'b0};
    vt[1]  = '{OP_SUB, 8'h07, 8'h05, 16'hFE00, 1'b0};
    vt[2]  = '{OP_SUB, 8'h01, 8'h00, 16'hFF00, 1'b0};
    vt[3]  = '{OP_ADD, 8'hFF, 8'h01, 16'h0000, 1'b0};
    vt[4]  = '{OP_MUL, 8'h03, 8'hFB, 16'hFFF1, 1'b0};
    vt[5]  = '{OP_MUL, 8'h7F, 8'h7F, 16'h3F01, 1'b0};
    vt[6]  = '{OP_MUL, 8'h81, 8'h80, 16'h3F80, 1'b0};
    vt[7]  = '{OP_MUL, 8'h00, 8'h55, 16'h0000, 1'b0};
    vt[8]  = '{OP_DIV, 8'h03, 8'h14, 16'h0206, 1'b0};
    vt[9]  = '{OP_DIV, 8'h7F, 8'hFF, 16'h0102, 1'b0};
    vt[10] = '{OP_DIV, 8'h01, 8'hFF, 16'h00FF, 1'b0};
    vt[11] = '{OP_DIV, 8'h00, 8'hAA, 16'h0000, 1'b1};
    vt[12] = '{OP_DIV, 8'h0A, 8'h05, 16'h0500, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    op    = OP_ADD;
    in_m  = 8'h00;
    in_q  = 8'h00;
    dp_op = OP_ADD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outs", int'(ctrl), 0);
    rst = 1'b0;

    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].m, vt[i].q,
             vt[i].exp, vt[i].err);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      rm = 8'($urandom);
      rq = 8'($urandom);
      if (ro == OP_MUL && rm == 8'h80) rm = 8'h7F;
      if (ro == OP_DIV)
        rm = ($urandom_range(0, 9) == 0) ? 8'h00
                                          : 8'($urandom_range(1, 127));
      run_op($sformatf("rnd%0d", n), ro, rm, rq,
             (ro == OP_DIV && rm == 8'h00) ? 16'h0000
                                           : ref_model(ro, rm, rq),
             ro == OP_DIV && rm == 8'h00);
    end

    // Reset in the middle of a multiply.
    @(negedge clk);
    dp_op = OP_MUL;
    in_m  = 8'h03;
    in_q  = 8'hFB;
    op    = OP_MUL;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("midmul busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midmul reset outs", int'(ctrl), 0);
    run_op("post_rst add", OP_ADD, 8'h22, 8'h11, 16'h3300, 1'b0);

    // Reset wins over start on the same edge.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    op    = OP_ADD;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_vs_start busy", int'(busy), 0);
    @(negedge clk);
    chk("rst_vs_start c0", int'(c0), 0);

    // Start pulses while busy, including on the done cycle.
    @(negedge clk);
    dp_op = OP_DIV;
    in_m  = 8'h03;
    in_q  = 8'h14;
    op    = OP_DIV;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    done1  = 0;
    idle_j = 0;
    for (int j = 1; j <= 40 && idle_j == 0; j++) begin
      @(negedge clk);
      if (done && done1 == 0) done1 = j;
      if (!busy) idle_j = j;
      start = (j == 5 || j == 12 || j == 28);
      op    = OP_ADD;
    end
    start = 1'b0;
    chk("busy_start done", done1, 28);
    chk("busy_start idle", idle_j, 29);
    @(negedge clk);
    chk("busy_start stays idle", int'(busy), 0);

    // Start held high: back-to-back adds.
    @(negedge clk);
    dp_op    = OP_ADD;
    in_m     = 8'h01;
    in_q     = 8'h02;
    op       = OP_ADD;
    start    = 1'b1;
    done1    = 0;
    done2    = 0;
    c0_after = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (done1 != 0 && c0 && c0_after == 0) c0_after = j;
      if (done && done1 != 0 && done2 == 0) done2 = j;
      if (done && done1 == 0) done1 = j;
    end
    start = 1'b0;
    chk("b2b first done", done1, 4);
    chk("b2b done_to_c0", c0_after - done1, 2);
    chk("b2b period", done2 - done1, 5);
    idle_j = 0;
    for (int j = 1; j <= 10 && idle_j == 0; j++) begin
      @(negedge clk);
      if (!busy) idle_j = j;
    end
    chk("b2b drains", int'(idle_j != 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
